// File: rtl/cnt_sweep_pkg.sv
// Shared defaults, state encoding and tag width for the sweep arbiter.
package cnt_sweep_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned W_DEF     = 5;
  localparam int unsigned TAG_W     = $clog2(N_REQ_DEF);

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/sweep_cnt.sv
// Signed W-bit sweep counter: load a value, step +1 with two's-complement wrap, or hold.
module sweep_cnt
  import cnt_sweep_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                inc,
  input  logic                hold,
  input  logic signed [W-1:0] load_val,
  output logic signed [W-1:0] value
);

  // Counter register; load has priority, increment only when not held.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc && !hold) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/cnt_sweep_arb.sv
// Round-robin owner of one shared sweep counter; streams tagged counter beats downstream.
module cnt_sweep_arb
  import cnt_sweep_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         start_val,
  input  logic [N_REQ*W-1:0]         end_val,
  input  logic                       hold,
  output logic [N_REQ-1:0]           grant,
  output logic signed [W-1:0]        out_num,
  output logic                       out_vld,
  output logic                       out_last,
  output logic [$clog2(N_REQ)-1:0]   out_tag,
  output logic                       busy
);

  localparam int unsigned TW = $clog2(N_REQ);

  state_t              state, state_d;
  logic [TW-1:0]       ptr, ptr_d;
  logic [TW-1:0]       win, win_d;
  logic signed [W-1:0] start_q, start_d;
  logic signed [W-1:0] end_q, end_d;
  logic [N_REQ-1:0]    grant_d;
  logic [TW-1:0]       tag_d;
  logic signed [W-1:0] num_d;
  logic                vld_d;
  logic                last_d;
  logic                busy_d;

  logic                found;
  logic [TW-1:0]       pick;

  logic                cnt_load;
  logic                cnt_inc;
  logic signed [W-1:0] cnt;
  logic signed [W-1:0] cnt_nx;

  sweep_cnt #(.W(W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .inc      (cnt_inc),
    .hold     (hold),
    .load_val (start_q),
    .value    (cnt)
  );

  assign cnt_nx = cnt + W'(1);

  // Circular priority search: first requester at or after the RR pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!found && req[TW'(ptr + TW'(k))]) begin
        found = 1'b1;
        pick  = TW'(ptr + TW'(k));
      end
    end
  end

  // Next-state and next-output logic; output registers present each beat.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    win_d    = win;
    start_d  = start_q;
    end_d    = end_q;
    grant_d  = grant;
    tag_d    = out_tag;
    num_d    = out_num;
    vld_d    = 1'b0;
    last_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          state_d = LOAD;
          win_d   = pick;
          start_d = start_val[pick*W +: W];
          end_d   = end_val[pick*W +: W];
          grant_d = N_REQ'(1) << pick;
          tag_d   = pick;
        end
      end
      LOAD: begin
        // First beat is the latched start, presented as the counter loads.
        cnt_load = 1'b1;
        num_d    = start_q;
        vld_d    = 1'b1;
        last_d   = (start_q == end_q);
        state_d  = RUN;
      end
      RUN: begin
        if (!hold) begin
          if (cnt == end_q) begin
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
            num_d   = cnt_nx;
            vld_d   = 1'b1;
            last_d  = (cnt_nx == end_q);
          end
        end
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = win + TW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, pointer, latched sweep bounds and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      start_q  <= '0;
      end_q    <= '0;
      grant    <= '0;
      out_tag  <= '0;
      out_num  <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      win      <= win_d;
      start_q  <= start_d;
      end_q    <= end_d;
      grant    <= grant_d;
      out_tag  <= tag_d;
      out_num  <= num_d;
      out_vld  <= vld_d;
      out_last <= last_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_cnt_sweep_arb.sv
// Directed bench for cnt_sweep_arb: table of single-lane sweeps plus multi-cycle sequences.
module tb_cnt_sweep_arb;
  import cnt_sweep_pkg::*;

  localparam int unsigned N = N_REQ_DEF;
  localparam int unsigned W = W_DEF;

  logic                clk;
  logic                rst;
  logic [N-1:0]        req;
  logic [N*W-1:0]      start_val;
  logic [N*W-1:0]      end_val;
  logic                hold;
  logic [N-1:0]        grant;
  logic signed [W-1:0] out_num;
  logic                out_vld;
  logic                out_last;
  logic [TAG_W-1:0]    out_tag;
  logic                busy;

  int n_run;
  int n_fail;

  typedef struct {
    int lane;
    int s;
    int e;
    int len;
    int last_v;
  } vec_t;

  vec_t vecs[5];

  cnt_sweep_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .start_val (start_val),
    .end_val   (end_val),
    .hold      (hold),
    .grant     (grant),
    .out_num   (out_num),
    .out_vld   (out_vld),
    .out_last  (out_last),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrapw(input int v);
    return (((v + 16) % 32) + 32) % 32 - 16;
  endfunction

  task automatic set_lane(input int lane, input int s, input int e);
    start_val[lane*W +: W] = W'(s);
    end_val[lane*W +: W]   = W'(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] oh;
    oh = N'(1) << v.lane;
    set_lane(v.lane, v.s, v.e);
    req = oh;
    tick();
    chk("load_grant", 32'(grant), 32'(oh));
    chk("load_vld", 32'(out_vld), 32'd0);
    chk("load_busy", 32'(busy), 32'd1);
    req = '0;
    for (int i = 0; i < v.len; i++) begin
      tick();
      chk("beat_vld", 32'(out_vld), 32'd1);
      chk("beat_num", 32'(out_num), 32'(wrapw(v.s + i)));
      chk("beat_last", 32'(out_last), (i == v.len - 1) ? 32'd1 : 32'd0);
      chk("beat_tag", 32'(out_tag), 32'(v.lane));
      chk("beat_grant", 32'(grant), 32'(oh));
      if (i == v.len - 1) chk("last_value", 32'(out_num), 32'(v.last_v));
    end
    tick();
    chk("done_vld", 32'(out_vld), 32'd0);
    chk("done_grant", 32'(grant), 32'(oh));
    tick();
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    req       = '0;
    hold      = 1'b0;
    start_val = '0;
    end_val   = '0;
    rst       = 1'b0;

    vecs[0] = '{lane: 0, s: -3,  e: 2,   len: 6, last_v: 2};
    vecs[1] = '{lane: 1, s: 14,  e: -15, len: 4, last_v: -15};
    vecs[2] = '{lane: 2, s: 5,   e: 5,   len: 1, last_v: 5};
    vecs[3] = '{lane: 3, s: -16, e: -14, len: 3, last_v: -14};
    vecs[4] = '{lane: 0, s: 15,  e: -16, len: 2, last_v: -16};

    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_num", 32'(out_num), 32'd0);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Fairness: all lanes request continuously, single-beat sweeps.
    do_reset();
    for (int l = 0; l < int'(N); l++) set_lane(l, 0, 0);
    req = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(N'(1) << (k % 4)));
      chk("rr_tag", 32'(out_tag), 32'(k % 4));
      tick();
      chk("rr_vld", 32'(out_vld), 32'd1);
      chk("rr_last", 32'(out_last), 32'd1);
      chk("rr_num", 32'(out_num), 32'd0);
      tick();
      chk("rr_done_vld", 32'(out_vld), 32'd0);
      tick();
      chk("rr_idle_grant", 32'(grant), 32'd0);
    end
    req = '0;

    // Hold: pointer now at 2, lane 0 still wins by wrap-around search.
    set_lane(0, 0, 3);
    req = 4'b0001;
    tick();
    chk("hold_grant", 32'(grant), 32'd1);
    req = '0;
    tick();
    chk("hold_b0", 32'(out_num), 32'd0);
    tick();
    chk("hold_b1", 32'(out_num), 32'd1);
    chk("hold_b1_vld", 32'(out_vld), 32'd1);
    hold = 1'b1;
    for (int g = 0; g < 2; g++) begin
      tick();
      chk("hold_gap_vld", 32'(out_vld), 32'd0);
      chk("hold_gap_num", 32'(out_num), 32'd1);
      chk("hold_gap_busy", 32'(busy), 32'd1);
    end
    hold = 1'b0;
    tick();
    chk("hold_b2", 32'(out_num), 32'd2);
    chk("hold_b2_vld", 32'(out_vld), 32'd1);
    chk("hold_b2_last", 32'(out_last), 32'd0);
    tick();
    chk("hold_b3", 32'(out_num), 32'd3);
    chk("hold_b3_last", 32'(out_last), 32'd1);
    tick();
    chk("hold_done_vld", 32'(out_vld), 32'd0);
    tick();
    chk("hold_idle_busy", 32'(busy), 32'd0);

    // Mid-sweep reset: pointer is 1 here, so a grant to lane 0 afterwards shows the pointer cleared.
    set_lane(0, 0, 9);
    set_lane(2, 7, 7);
    req = 4'b0001;
    tick();
    chk("mr_grant", 32'(grant), 32'd1);
    req = '0;
    for (int b = 0; b < 5; b++) tick();
    chk("mr_b5", 32'(out_num), 32'd4);
    chk("mr_b5_vld", 32'(out_vld), 32'd1);
    rst = 1'b1;
    req = 4'b0101;
    tick();
    chk("mr_grant0", 32'(grant), 32'd0);
    chk("mr_num0", 32'(out_num), 32'd0);
    chk("mr_vld0", 32'(out_vld), 32'd0);
    chk("mr_last0", 32'(out_last), 32'd0);
    chk("mr_tag0", 32'(out_tag), 32'd0);
    chk("mr_busy0", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("mr_regrant", 32'(grant), 32'd1);
    chk("mr_retag", 32'(out_tag), 32'd0);
    req = '0;
    do_reset();

    // Input isolation: bounds change after grant must not affect the sweep.
    set_lane(2, 3, 6);
    req = 4'b0100;
    tick();
    chk("iso_grant", 32'(grant), 32'b0100);
    set_lane(2, -10, 0);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("iso_num", 32'(out_num), 32'(3 + i));
      chk("iso_vld", 32'(out_vld), 32'd1);
      chk("iso_last", 32'(out_last), (i == 3) ? 32'd1 : 32'd0);
      chk("iso_tag", 32'(out_tag), 32'd2);
    end
    tick();
    chk("iso_done_vld", 32'(out_vld), 32'd0);
    chk("iso_done_last", 32'(out_last), 32'd0);
    tick();
    chk("iso_idle_grant", 32'(grant), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
